// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared types and constants for the sequenced RAM controller.
//   state_t        controller FSM states
//   MAX_RD_LATENCY largest supported RAM read latency (RD_LATENCY range 1..MAX_RD_LATENCY)
//   CNT_W          width of the read-latency down-counter
//   ERR_RDATA      read data returned for out-of-window reads (range-check builds only)
package ram_ctrl_pkg;

  localparam int          MAX_RD_LATENCY = 4;
  localparam int          CNT_W          = $clog2(MAX_RD_LATENCY);
  localparam logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    RD_ISSUE = 2'd2,
    RD_WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/ram_ctrl_addr_map.sv
// ram_ctrl_addr_map: maps a core byte address onto the RAM word index.
//   cpu_addr   in   32      byte address from the core
//   word_idx   out  ADDR_W  (cpu_addr - BASE_ADDR)[ADDR_W+1:2]; upper bits are dropped,
//                           so addresses outside the window alias inside it
//   in_window  out  1       present only with RAM_CTRL_RANGE_CHECK_EN defined:
//                           cpu_addr lies in [BASE_ADDR, BASE_ADDR + 4*2**ADDR_W)
module ram_ctrl_addr_map
  import ram_ctrl_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic [31:0]       cpu_addr,
  output logic [ADDR_W-1:0] word_idx
`ifdef RAM_CTRL_RANGE_CHECK_EN
  ,
  output logic              in_window
`endif
);

  logic [31:0] offset;

  assign offset   = cpu_addr - BASE_ADDR;
  assign word_idx = offset[ADDR_W+1:2];

`ifdef RAM_CTRL_RANGE_CHECK_EN
  // Addresses below BASE_ADDR wrap to a huge offset, so one upper-bits test covers both ends.
  assign in_window = (offset[31:ADDR_W+2] == '0);

  logic unused_lsb;
  assign unused_lsb = ^offset[1:0];
`else
  logic unused_bits;
  assign unused_bits = ^{offset[31:ADDR_W+2], offset[1:0]};
`endif

endmodule

// File: rtl/ram_ctrl_seq.sv
// ram_ctrl_seq: sequenced bridge between the core data port and a synchronous single-port RAM.
// Requests are sampled only in IDLE; a simultaneous write and read runs the write first.
// Optional feature macro: RAM_CTRL_RANGE_CHECK_EN (out-of-window accesses are suppressed,
// reads return ERR_RDATA and the sticky cpu_err flag is raised).
//   clk, reset    clock, asynchronous active-high reset
//   cpu_addr      byte address          cpu_wdata  write data
//   cpu_wmask     byte enables (!=0 => write request)
//   cpu_rstrb     read request strobe
//   cpu_rdata     registered read data, valid when cpu_rbusy falls
//   cpu_rbusy     read in progress      cpu_wbusy  write in progress
//   cpu_err       sticky out-of-window flag (0 without the macro)
//   ram_addr      registered word address   ram_wdata  registered write data
//   ram_wen       one-cycle write strobe     ram_rden   one-cycle read strobe
//   ram_byteena   registered byte enables    ram_q      RAM read data
module ram_ctrl_seq
  import ram_ctrl_pkg::*;
#(
  parameter int          ADDR_W     = 10,
  parameter int          DATA_W     = 32,
  parameter int          RD_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [DATA_W/8-1:0]   cpu_wmask,
  input  logic                  cpu_rstrb,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_rbusy,
  output logic                  cpu_wbusy,
  output logic                  cpu_err,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic                  ram_wen,
  output logic                  ram_rden,
  output logic [DATA_W/8-1:0]   ram_byteena,
  input  logic [DATA_W-1:0]     ram_q
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

  state_t              state, next_state;
  logic                rd_pending;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   word_idx;
  logic                acc_ok;    // request in the current cycle may touch the RAM
  logic                issue_ok;  // latched request may touch the RAM
  logic [DATA_W-1:0]   rd_value;

`ifdef RAM_CTRL_RANGE_CHECK_EN
  logic in_window;
  logic win;

  ram_ctrl_addr_map #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) u_addr_map (
    .cpu_addr  (cpu_addr),
    .word_idx  (word_idx),
    .in_window (in_window)
  );

  assign acc_ok   = in_window;
  assign issue_ok = win;
  assign rd_value = win ? ram_q : DATA_W'(ERR_RDATA);

  // win tracks the request being accepted; it freezes once the FSM leaves IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win     <= 1'b0;
      cpu_err <= 1'b0;
    end else if (state == IDLE) begin
      win <= in_window;
      if (((|cpu_wmask) || cpu_rstrb) && !in_window)
        cpu_err <= 1'b1;
    end
  end
`else
  ram_ctrl_addr_map #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) u_addr_map (
    .cpu_addr (cpu_addr),
    .word_idx (word_idx)
  );

  assign acc_ok   = 1'b1;
  assign issue_ok = 1'b1;
  assign rd_value = ram_q;
  assign cpu_err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Busy flags rise combinationally in the request cycle so the core stalls immediately.
  always_comb begin
    next_state = state;
    cpu_wbusy  = 1'b0;
    cpu_rbusy  = 1'b0;
    case (state)
      IDLE: begin
        cpu_wbusy = |cpu_wmask;
        cpu_rbusy = cpu_rstrb;
        if (|cpu_wmask)     next_state = WRITE;
        else if (cpu_rstrb) next_state = RD_ISSUE;
      end
      WRITE: begin
        cpu_wbusy  = 1'b1;
        cpu_rbusy  = rd_pending;
        next_state = rd_pending ? RD_ISSUE : IDLE;
      end
      RD_ISSUE: begin
        cpu_rbusy  = 1'b1;
        next_state = RD_WAIT;
      end
      RD_WAIT: begin
        cpu_rbusy = 1'b1;
        if (cnt == '0) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Strobes are registered on the edge that leaves the current state, so each one is high
  // for exactly the cycle spent in WRITE / RD_ISSUE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_byteena <= '0;
      ram_wen     <= 1'b0;
      ram_rden    <= 1'b0;
      cpu_rdata   <= '0;
      cnt         <= '0;
      rd_pending  <= 1'b0;
    end else begin
      ram_wen  <= 1'b0;
      ram_rden <= 1'b0;
      case (state)
        IDLE: begin
          if (|cpu_wmask) begin
            ram_addr    <= word_idx;
            ram_wdata   <= cpu_wdata;
            ram_byteena <= cpu_wmask;
            ram_wen     <= acc_ok;
            rd_pending  <= cpu_rstrb;
          end else if (cpu_rstrb) begin
            ram_addr <= word_idx;
            ram_rden <= acc_ok;
          end
        end
        WRITE: begin
          if (rd_pending) begin
            ram_rden   <= issue_ok;
            rd_pending <= 1'b0;
          end
        end
        RD_ISSUE: cnt <= CNT_LOAD;
        RD_WAIT: begin
          if (cnt == '0) cpu_rdata <= rd_value;
          else           cnt       <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ctrl_seq.sv
module tb_ram_ctrl_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0]  cpu_wmask = '0;
  logic        cpu_rstrb = 1'b0;

  // Instance A: RD_LATENCY=1, Instance B: RD_LATENCY=3; both see the same core requests.
  logic [31:0] rdata_a, wdata_a, q_a, rdata_b, wdata_b, q_b;
  logic        rbusy_a, wbusy_a, err_a, wen_a, rden_a;
  logic        rbusy_b, wbusy_b, err_b, wen_b, rden_b;
  logic [9:0]  addr_a, addr_b;
  logic [3:0]  be_a, be_b;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  logic [127:0] exp_wen_q[$];
  logic [127:0] exp_rden_q[$];
  logic [127:0] exp_wdone_q[$];
  logic [127:0] exp_rd_a_q[$];
  logic [127:0] exp_rd_b_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_ctrl_seq #(.ADDR_W(10), .DATA_W(32), .RD_LATENCY(1), .BASE_ADDR(32'h0)) dut_a (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wmask(cpu_wmask), .cpu_rstrb(cpu_rstrb), .cpu_rdata(rdata_a),
    .cpu_rbusy(rbusy_a), .cpu_wbusy(wbusy_a), .cpu_err(err_a), .ram_addr(addr_a),
    .ram_wdata(wdata_a), .ram_wen(wen_a), .ram_rden(rden_a), .ram_byteena(be_a),
    .ram_q(q_a)
  );

  ram_ctrl_seq #(.ADDR_W(10), .DATA_W(32), .RD_LATENCY(3), .BASE_ADDR(32'h0)) dut_b (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wmask(cpu_wmask), .cpu_rstrb(cpu_rstrb), .cpu_rdata(rdata_b),
    .cpu_rbusy(rbusy_b), .cpu_wbusy(wbusy_b), .cpu_err(err_b), .ram_addr(addr_b),
    .ram_wdata(wdata_b), .ram_wen(wen_b), .ram_rden(rden_b), .ram_byteena(be_b),
    .ram_q(q_b)
  );

  // RAM models; q is zero whenever no read is due, so a mistimed capture shows up.
  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];
  logic [31:0] s0_b, s1_b;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wen_a && be_a[i]) mem_a[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
      if (wen_b && be_b[i]) mem_b[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
    end
    q_a  <= rden_a ? mem_a[addr_a] : 32'h0;
    s0_b <= rden_b ? mem_b[addr_b] : 32'h0;
    s1_b <= s0_b;
    q_b  <= s1_b;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event at cycle %0d, required none", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever a DUT event is seen.
  logic pw = 1'b0, pra = 1'b0, prb = 1'b0;
  logic [127:0] e;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        pw = 1'b0; pra = 1'b0; prb = 1'b0;
      end else begin
        if (wen_a) begin
          if (exp_wen_q.size() == 0) unexpected("ram_wen");
          else begin
            e = exp_wen_q.pop_front();
            chk("ram_wen {cyc,addr,wdata,be}", {cyc, addr_a, wdata_a, be_a}, e);
          end
        end
        if (rden_a) begin
          if (exp_rden_q.size() == 0) unexpected("ram_rden");
          else begin
            e = exp_rden_q.pop_front();
            chk("ram_rden {cyc,addr}", {cyc, addr_a}, e);
          end
        end
        if (pw && !wbusy_a) begin
          if (exp_wdone_q.size() == 0) unexpected("wbusy fall");
          else begin
            e = exp_wdone_q.pop_front();
            chk("wbusy fall cyc", 128'(cyc), e);
          end
        end
        if (pra && !rbusy_a) begin
          if (exp_rd_a_q.size() == 0) unexpected("rbusy fall lat1");
          else begin
            e = exp_rd_a_q.pop_front();
            chk("lat1 read {cyc,rdata}", {cyc, rdata_a}, e);
          end
        end
        if (prb && !rbusy_b) begin
          if (exp_rd_b_q.size() == 0) unexpected("rbusy fall lat3");
          else begin
            e = exp_rd_b_q.pop_front();
            chk("lat3 read {cyc,rdata}", {cyc, rdata_b}, e);
          end
        end
        pw  = wbusy_a;
        pra = rbusy_a;
        prb = rbusy_b;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((rbusy_a || wbusy_a || rbusy_b || wbusy_b) && n < 60);
    if (n >= 60) unexpected("timeout waiting for idle");
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] mask, input logic [9:0] word);
    int t;
    cpu_addr = addr; cpu_wdata = data; cpu_wmask = mask;
    t = cyc;
    exp_wen_q.push_back({32'(t + 1), word, data, mask});
    exp_wdone_q.push_back(128'(t + 2));
    #1 chk("wbusy in request cycle", 128'(wbusy_a), 128'(1));
    @(negedge clk); #1;
    cpu_wmask = '0;
    wait_idle();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [9:0] word,
                         input logic [31:0] expd, input bit rden_ok, input bit use_b);
    int t;
    cpu_addr = addr; cpu_rstrb = 1'b1;
    t = cyc;
    if (rden_ok) exp_rden_q.push_back({32'(t + 1), word});
    exp_rd_a_q.push_back({32'(t + 3), expd});
    if (use_b) exp_rd_b_q.push_back({32'(t + 5), expd});
    #1 chk("rbusy in request cycle", 128'(rbusy_a), 128'(1));
    @(negedge clk); #1;
    cpu_rstrb = 1'b0;
    if (use_b) wait_idle();
  endtask

  task automatic do_wr_rd(input logic [31:0] addr, input logic [31:0] data,
                          input logic [9:0] word, input logic [31:0] expd);
    int t;
    cpu_addr = addr; cpu_wdata = data; cpu_wmask = 4'hF; cpu_rstrb = 1'b1;
    t = cyc;
    exp_wen_q.push_back({32'(t + 1), word, data, 4'hF});
    exp_wdone_q.push_back(128'(t + 2));
    exp_rden_q.push_back({32'(t + 2), word});
    exp_rd_a_q.push_back({32'(t + 4), expd});
    exp_rd_b_q.push_back({32'(t + 6), expd});
    @(negedge clk); #1;
    chk("wr+rd rbusy held in WRITE", 128'(rbusy_a), 128'(1));
    chk("wr+rd wbusy held in WRITE", 128'(wbusy_a), 128'(1));
    cpu_wmask = '0; cpu_rstrb = 1'b0;
    wait_idle();
  endtask

  task automatic chk_zero(input string tag, input logic [31:0] rdata, input logic rbusy,
                          input logic wbusy, input logic err, input logic [9:0] addr,
                          input logic [31:0] wdata, input logic wen, input logic rden,
                          input logic [3:0] be);
    chk({tag, " cpu_rdata"}, 128'(rdata), 128'(0));
    chk({tag, " cpu_rbusy"}, 128'(rbusy), 128'(0));
    chk({tag, " cpu_wbusy"}, 128'(wbusy), 128'(0));
    chk({tag, " cpu_err"},   128'(err),   128'(0));
    chk({tag, " ram_addr"},  128'(addr),  128'(0));
    chk({tag, " ram_wdata"}, 128'(wdata), 128'(0));
    chk({tag, " ram_wen"},   128'(wen),   128'(0));
    chk({tag, " ram_rden"},  128'(rden),  128'(0));
    chk({tag, " ram_byteena"}, 128'(be),  128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout at cycle %0d", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset", rdata_a, rbusy_a, wbusy_a, err_a, addr_a, wdata_a, wen_a, rden_a, be_a);
    reset = 1'b0;
    @(negedge clk); #1;

    // Seed word 0 for the aliasing check later.
    do_write(32'h0000_0000, 32'h0BAD_CAFE, 4'hF, 10'd0);

    // Full-word write and read-back at 0x10 (word 4).
    do_write(32'h0000_0010, 32'h1234_5678, 4'hF, 10'd4);
    do_read(32'h0000_0010, 10'd4, 32'h1234_5678, 1'b1, 1'b1);

    // Single byte lane 2 write, then read-back merged word.
    do_write(32'h0000_0010, 32'hAABB_CCDD, 4'b0100, 10'd4);
    do_read(32'h0000_0010, 10'd4, 32'h12BB_5678, 1'b1, 1'b1);

    // Write and read in the same request cycle at 0x20 (word 8).
    do_wr_rd(32'h0000_0020, 32'hCAFE_F00D, 10'd8, 32'hCAFE_F00D);

    // A write leaves the last read data untouched.
    do_write(32'h0000_0024, 32'h1111_2222, 4'hF, 10'd9);
    chk("rdata held across write", 128'(rdata_a), 128'(32'hCAFE_F00D));

    // Reset in the middle of a latency-3 read (lat-1 instance completes first).
    do_read(32'h0000_0020, 10'd8, 32'hCAFE_F00D, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #2;
    chk("lat3 still busy before reset", 128'(rbusy_b), 128'(1));
    reset = 1'b1;
    #1;
    chk_zero("mid-read reset", rdata_b, rbusy_b, wbusy_b, err_b, addr_b, wdata_b, wen_b, rden_b, be_b);
    chk("mid-read reset lat1 cpu_rdata", 128'(rdata_a), 128'(0));
    @(negedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    do_read(32'h0000_0024, 10'd9, 32'h1111_2222, 1'b1, 1'b1);

`ifdef RAM_CTRL_RANGE_CHECK_EN
    // 0x1000 is one byte past the 4 KiB window: no RAM access, error data, sticky flag.
    do_read(32'h0000_1000, 10'd0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    chk("cpu_err after out-of-window read", 128'(err_a), 128'(1));
    chk("cpu_err lat3 after out-of-window read", 128'(err_b), 128'(1));
    do_read(32'h0000_0010, 10'd4, 32'h12BB_5678, 1'b1, 1'b1);
    chk("cpu_err sticky", 128'(err_a), 128'(1));
    reset = 1'b1;
    #1 chk("cpu_err cleared by reset", 128'(err_a), 128'(0));
    @(negedge clk); #1;
    reset = 1'b0;
`else
    // Without range check 0x1000 wraps to word 0.
    do_read(32'h0000_1000, 10'd0, 32'h0BAD_CAFE, 1'b1, 1'b1);
    chk("cpu_err tied low", 128'(err_a), 128'(0));
`endif

    repeat (4) @(negedge clk);
    #1;
    chk("leftover ram_wen events",  128'(exp_wen_q.size()),   128'(0));
    chk("leftover ram_rden events", 128'(exp_rden_q.size()),  128'(0));
    chk("leftover wbusy events",    128'(exp_wdone_q.size()), 128'(0));
    chk("leftover lat1 reads",      128'(exp_rd_a_q.size()),  128'(0));
    chk("leftover lat3 reads",      128'(exp_rd_b_q.size()),  128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
